// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//
// Instruction-address sequencer with a call stack, a hardware loop stack and
// a three-state control FSM (RUN / HALTED / FAULT).
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   op          in   decoded opcode (SEQ JUMP BR CALL RET LOOP ENDL HALT)
//   target      in   absolute address for JUMP / CALL
//   rel         in   signed relative offset for BR
//   loop_count  in   iteration count for LOOP (0 is treated as 1)
//   cond        in   branch condition for BR
//   stall       in   freeze all sequencer state for this cycle
//   resume      in   leave HALTED
//   pc          out  registered program counter
//   next_pc     out  combinational value pc takes at the next edge
//   call_level  out  occupied call stack entries
//   loop_level  out  occupied loop stack entries
//   halted      out  high in HALTED
//   fault       out  high in FAULT
//   fault_code  out  0 call overflow, 1 return underflow,
//                    2 loop overflow, 3 loop underflow
// ---------------------------------------------------------------------------
module program_sequencer #(
    parameter int PC_W       = 10,
    parameter int CALL_DEPTH = 16,
    parameter int LOOP_DEPTH = 4,
    parameter int REL_W      = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    op,
    input  logic [PC_W-1:0]               target,
    input  logic [REL_W-1:0]              rel,
    input  logic [CNT_W-1:0]              loop_count,
    input  logic                          cond,
    input  logic                          stall,
    input  logic                          resume,
    output logic [PC_W-1:0]               pc,
    output logic [PC_W-1:0]               next_pc,
    output logic [$clog2(CALL_DEPTH):0]   call_level,
    output logic [$clog2(LOOP_DEPTH):0]   loop_level,
    output logic                          halted,
    output logic                          fault,
    output logic [1:0]                    fault_code
);

    localparam int CA_W = $clog2(CALL_DEPTH);
    localparam int LA_W = $clog2(LOOP_DEPTH);

    localparam logic [CA_W:0] CALL_FULL = (CA_W+1)'(CALL_DEPTH);
    localparam logic [LA_W:0] LOOP_FULL = (LA_W+1)'(LOOP_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_LOOP = 3'd5;
    localparam logic [2:0] OP_ENDL = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [1:0] FC_CALL_OVF  = 2'd0;
    localparam logic [1:0] FC_RET_UNF   = 2'd1;
    localparam logic [1:0] FC_LOOP_OVF  = 2'd2;
    localparam logic [1:0] FC_LOOP_UNF  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [CA_W:0]       call_level_q, call_level_d;
    logic [LA_W:0]       loop_level_q, loop_level_d;
    logic [1:0]          fault_code_q, fault_code_d;

    // Stack storage; contents are don't-care above the level pointers,
    // so they carry no reset.
    logic [PC_W-1:0]     call_stack_q [CALL_DEPTH];
    logic [PC_W-1:0]     loop_start_q [LOOP_DEPTH];
    logic [CNT_W-1:0]    loop_cnt_q   [LOOP_DEPTH];

    logic                call_push_s;
    logic                loop_push_s;
    logic                loop_dec_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     rel_ext_s;
    logic [CA_W-1:0]     call_push_idx_s;
    logic [CA_W-1:0]     call_top_idx_s;
    logic [LA_W-1:0]     loop_push_idx_s;
    logic [LA_W-1:0]     loop_top_idx_s;
    logic [CNT_W-1:0]    loop_top_cnt_s;
    logic [CNT_W-1:0]    loop_new_cnt_s;

    assign pc_inc_s        = pc_q + PC_W'(1);
    // Sized cast of a signed value sign-extends rel to PC_W.
    assign rel_ext_s       = PC_W'($signed(rel));
    // Level counts entries, so the push slot is the level and the top is one below.
    assign call_push_idx_s = call_level_q[CA_W-1:0];
    assign call_top_idx_s  = call_push_idx_s - CA_W'(1);
    assign loop_push_idx_s = loop_level_q[LA_W-1:0];
    assign loop_top_idx_s  = loop_push_idx_s - LA_W'(1);
    assign loop_top_cnt_s  = loop_cnt_q[loop_top_idx_s];
    assign loop_new_cnt_s  = (loop_count == {CNT_W{1'b0}}) ? CNT_W'(1) : loop_count;

    // Next-state decode: pc, levels, FSM state and stack write strobes.
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        call_level_d = call_level_q;
        loop_level_d = loop_level_q;
        fault_code_d = fault_code_q;
        call_push_s  = 1'b0;
        loop_push_s  = 1'b0;
        loop_dec_s   = 1'b0;

        if (stall) begin
            pc_d = pc_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    case (op)
                        OP_SEQ:  pc_d = pc_inc_s;
                        OP_JUMP: pc_d = target;
                        OP_BR: begin
                            if (cond) begin
                                pc_d = pc_q + rel_ext_s;
                            end else begin
                                pc_d = pc_inc_s;
                            end
                        end
                        OP_CALL: begin
                            if (call_level_q == CALL_FULL) begin
                                state_d      = ST_FAULT;
                                fault_code_d = FC_CALL_OVF;
                            end else begin
                                call_push_s  = 1'b1;
                                call_level_d = call_level_q + (CA_W+1)'(1);
                                pc_d         = target;
                            end
                        end
                        OP_RET: begin
                            if (call_level_q == '0) begin
                                state_d      = ST_FAULT;
                                fault_code_d = FC_RET_UNF;
                            end else begin
                                call_level_d = call_level_q - (CA_W+1)'(1);
                                pc_d         = call_stack_q[call_top_idx_s];
                            end
                        end
                        OP_LOOP: begin
                            if (loop_level_q == LOOP_FULL) begin
                                state_d      = ST_FAULT;
                                fault_code_d = FC_LOOP_OVF;
                            end else begin
                                loop_push_s  = 1'b1;
                                loop_level_d = loop_level_q + (LA_W+1)'(1);
                                pc_d         = pc_inc_s;
                            end
                        end
                        OP_ENDL: begin
                            if (loop_level_q == '0) begin
                                state_d      = ST_FAULT;
                                fault_code_d = FC_LOOP_UNF;
                            end else if (loop_top_cnt_s > CNT_W'(1)) begin
                                loop_dec_s = 1'b1;
                                pc_d       = loop_start_q[loop_top_idx_s];
                            end else begin
                                loop_level_d = loop_level_q - (LA_W+1)'(1);
                                pc_d         = pc_inc_s;
                            end
                        end
                        OP_HALT: state_d = ST_HALTED;
                        default: pc_d = pc_inc_s;
                    endcase
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_d = ST_RUN;
                        pc_d    = pc_inc_s;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

    // Control FSM and architectural registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            call_level_q <= '0;
            loop_level_q <= '0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            call_level_q <= call_level_d;
            loop_level_q <= loop_level_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Stack storage writes; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (call_push_s) begin
                call_stack_q[call_push_idx_s] <= pc_inc_s;
            end
            if (loop_push_s) begin
                loop_start_q[loop_push_idx_s] <= pc_inc_s;
                loop_cnt_q[loop_push_idx_s]   <= loop_new_cnt_s;
            end else if (loop_dec_s) begin
                loop_cnt_q[loop_top_idx_s]    <= loop_top_cnt_s - CNT_W'(1);
            end
        end
    end

    assign pc         = pc_q;
    assign next_pc    = pc_d;
    assign call_level = call_level_q;
    assign loop_level = loop_level_q;
    assign fault_code = fault_code_q;
    assign halted     = (state_q == ST_HALTED);
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
//
// Directed scenarios plus a randomized run, checked against a queue-based
// behavioural model. A second instance with PC_W=4 covers pc wrap-around.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [9:0]  target;
    logic [7:0]  rel;
    logic [7:0]  loop_count;
    logic        cond;
    logic        stall;
    logic        resume;
    logic [9:0]  pc;
    logic [9:0]  next_pc;
    logic [4:0]  call_level;
    logic [2:0]  loop_level;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    logic [2:0]  op2;
    logic [3:0]  target2;
    logic [3:0]  pc2;
    logic [3:0]  next_pc2;
    logic [4:0]  call_level2;
    logic [2:0]  loop_level2;
    logic        halted2;
    logic        fault2;
    logic [1:0]  fault_code2;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    int m_pc;
    int m_state;          // 0 run, 1 halted, 2 fault
    int m_code;
    int call_q[$];
    int lstart_q[$];
    int lcnt_q[$];

    program_sequencer dut (
        .clk(clk), .rst(rst), .op(op), .target(target), .rel(rel),
        .loop_count(loop_count), .cond(cond), .stall(stall), .resume(resume),
        .pc(pc), .next_pc(next_pc), .call_level(call_level),
        .loop_level(loop_level), .halted(halted), .fault(fault),
        .fault_code(fault_code)
    );

    program_sequencer #(.PC_W(4), .REL_W(4)) dut2 (
        .clk(clk), .rst(rst), .op(op2), .target(target2), .rel(rel[3:0]),
        .loop_count(loop_count), .cond(cond), .stall(stall), .resume(resume),
        .pc(pc2), .next_pc(next_pc2), .call_level(call_level2),
        .loop_level(loop_level2), .halted(halted2), .fault(fault2),
        .fault_code(fault_code2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_fault(input int code);
        m_state = 2;
        m_code  = code;
    endtask

    task automatic model_step(input bit r, input int o, input int tgt, input int rl,
                              input int lc, input bit c, input bit st, input bit rs);
        int srel;
        srel = (rl >= 128) ? rl - 256 : rl;
        if (r) begin
            m_pc = 0; m_state = 0; m_code = 0;
            call_q.delete(); lstart_q.delete(); lcnt_q.delete();
        end else if (st || m_state == 2) begin
            m_pc = m_pc;
        end else if (m_state == 1) begin
            if (rs) begin
                m_state = 0;
                m_pc = wrap(m_pc + 1);
            end
        end else begin
            case (o)
                0: m_pc = wrap(m_pc + 1);
                1: m_pc = tgt;
                2: m_pc = c ? wrap(m_pc + srel) : wrap(m_pc + 1);
                3: if (call_q.size() == 16) model_fault(0);
                   else begin call_q.push_back(wrap(m_pc + 1)); m_pc = tgt; end
                4: if (call_q.size() == 0) model_fault(1);
                   else m_pc = call_q.pop_back();
                5: if (lstart_q.size() == 4) model_fault(2);
                   else begin
                       lstart_q.push_back(wrap(m_pc + 1));
                       lcnt_q.push_back((lc == 0) ? 1 : lc);
                       m_pc = wrap(m_pc + 1);
                   end
                6: if (lstart_q.size() == 0) model_fault(3);
                   else if (lcnt_q[lcnt_q.size()-1] > 1) begin
                       lcnt_q[lcnt_q.size()-1] = lcnt_q[lcnt_q.size()-1] - 1;
                       m_pc = lstart_q[lstart_q.size()-1];
                   end else begin
                       void'(lstart_q.pop_back());
                       void'(lcnt_q.pop_back());
                       m_pc = wrap(m_pc + 1);
                   end
                default: m_state = 1;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},         32'(pc),         32'(m_pc));
        chk({tag, ".call_level"}, 32'(call_level), 32'(call_q.size()));
        chk({tag, ".loop_level"}, 32'(loop_level), 32'(lstart_q.size()));
        chk({tag, ".halted"},     32'(halted),     32'(m_state == 1));
        chk({tag, ".fault"},      32'(fault),      32'(m_state == 2));
        chk({tag, ".fault_code"}, 32'(fault_code), 32'(m_code));
    endtask

    task automatic step(input bit r, input int o, input int tgt, input int rl,
                        input int lc, input bit c, input bit st, input bit rs,
                        input string tag);
        rst = r; op = 3'(o); target = 10'(tgt); rel = 8'(rl);
        loop_count = 8'(lc); cond = c; stall = st; resume = rs;
        model_step(r, o, tgt, rl, lc, c, st, rs);
        #1;
        if (!r) chk({tag, ".next_pc"}, 32'(next_pc), 32'(m_pc));
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_op(input int o, input int tgt, input string tag);
        step(1'b0, o, tgt, 0, 0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1; op = 3'd0; target = 10'd0; rel = 8'd0; loop_count = 8'd0;
        cond = 1'b0; stall = 1'b0; resume = 1'b0; op2 = 3'd0; target2 = 4'd0;
        m_pc = 0; m_state = 0; m_code = 0;

        // Reset values
        do_reset("reset");
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);

        // Sequential and branch
        for (int k = 1; k <= 3; k++) begin
            do_op(0, 0, "seq");
            chk("seq_pc", 32'(pc), 32'(k));
        end
        step(1'b0, 2, 0, 8'hFE, 0, 1'b1, 1'b0, 1'b0, "br_taken");
        chk("br_taken_pc", 32'(pc), 32'd1);
        step(1'b0, 2, 0, 8'hFE, 0, 1'b0, 1'b0, 1'b0, "br_not_taken");
        chk("br_not_taken_pc", 32'(pc), 32'd2);

        // Call and return
        do_op(1, 5, "jump5");
        do_op(3, 'h40, "call");
        chk("call_pc", 32'(pc), 32'h40);
        chk("call_lvl", 32'(call_level), 32'd1);
        do_op(0, 0, "call_body");
        do_op(4, 0, "ret");
        chk("ret_pc", 32'(pc), 32'd6);
        chk("ret_lvl", 32'(call_level), 32'd0);

        // Hardware loop: three iterations, then loop_count 0 runs once
        do_op(1, 10, "jump10");
        step(1'b0, 5, 0, 0, 3, 1'b0, 1'b0, 1'b0, "loop3");
        for (int i = 0; i < 3; i++) begin
            chk("loop_body_pc", 32'(pc), 32'd11);
            do_op(0, 0, "loop_body");
            do_op(6, 0, "endl");
        end
        chk("loop_exit_pc", 32'(pc), 32'd13);
        chk("loop_exit_lvl", 32'(loop_level), 32'd0);
        do_op(1, 10, "jump10b");
        step(1'b0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0, "loop0");
        do_op(0, 0, "loop0_body");
        do_op(6, 0, "endl0");
        chk("loop0_exit_pc", 32'(pc), 32'd13);

        // Stall during CALL: no push, pc held
        step(1'b0, 3, 'h100, 0, 0, 1'b0, 1'b1, 1'b0, "stall_call");
        chk("stall_pc", 32'(pc), 32'd13);
        chk("stall_lvl", 32'(call_level), 32'd0);

        // Halt and resume
        do_op(1, 7, "jump7");
        do_op(7, 0, "halt");
        for (int i = 0; i < 5; i++) begin
            do_op(0, 0, "halted_hold");
            chk("halt_pc", 32'(pc), 32'd7);
            chk("halt_flag", 32'(halted), 32'd1);
        end
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, "resume_stalled");
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, "resume");
        chk("resume_pc", 32'(pc), 32'd8);
        chk("resume_halted", 32'(halted), 32'd0);

        // Call stack fill and overflow
        do_reset("reset_ovf");
        for (int i = 0; i < 16; i++) do_op(3, 'h20 + i, "call_fill");
        chk("call_full_lvl", 32'(call_level), 32'd16);
        chk("call_full_fault", 32'(fault), 32'd0);
        do_op(3, 'h300, "call_ovf");
        chk("call_ovf_fault", 32'(fault), 32'd1);
        chk("call_ovf_code", 32'(fault_code), 32'd0);
        chk("call_ovf_pc", 32'(pc), 32'h2F);
        do_op(4, 0, "fault_sticky_ret");
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, "fault_sticky_resume");
        do_reset("reset_after_fault");
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_lvl", 32'(call_level), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // Underflows and loop overflow
        do_op(4, 0, "ret_unf");
        chk("ret_unf_code", 32'(fault_code), 32'd1);
        do_reset("reset_unf");
        do_op(6, 0, "endl_unf");
        chk("endl_unf_code", 32'(fault_code), 32'd3);
        do_reset("reset_lovf");
        for (int i = 0; i < 4; i++) step(1'b0, 5, 0, 0, 2, 1'b0, 1'b0, 1'b0, "loop_fill");
        chk("loop_full_lvl", 32'(loop_level), 32'd4);
        step(1'b0, 5, 0, 0, 2, 1'b0, 1'b0, 1'b0, "loop_ovf");
        chk("loop_ovf_code", 32'(fault_code), 32'd2);
        chk("loop_ovf_pc", 32'(pc), 32'd4);

        // Randomized run against the model
        do_reset("reset_rand");
        for (int n = 0; n < 400; n++) begin
            int o;
            o = int'($urandom_range(0, 7));
            if (o == 4 && call_q.size() == 0 && $urandom_range(0, 9) != 0) o = 0;
            if (o == 6 && lstart_q.size() == 0 && $urandom_range(0, 9) != 0) o = 0;
            if (o == 7 && $urandom_range(0, 3) != 0) o = 0;
            if (m_state == 2 && $urandom_range(0, 3) == 0) begin
                do_reset("rand_reset");
            end else begin
                step(1'b0, o, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rand");
            end
        end

        // Narrow-pc instance: wrap-around at PC_W=4
        do_reset("reset_wrap");
        op2 = 3'd1; target2 = 4'd15;
        do_op(0, 0, "wrap_jump");
        chk("wrap_jump_pc2", 32'(pc2), 32'd15);
        op2 = 3'd0;
        do_op(0, 0, "wrap_seq");
        chk("wrap_seq_pc2", 32'(pc2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter CALL_DEPTH, default 16, call stack entries; SHALL be a power of two, at least 2.
REQ-003 Parameter LOOP_DEPTH, default 4, hardware loop stack entries; SHALL be a power of two, at least 2.
REQ-004 Parameter REL_W, default 8, signed relative branch offset width; SHALL be at most PC_W.
REQ-005 Parameter CNT_W, default 8, loop iteration count width.
REQ-006 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 op  in  3  decoded opcode: 0 SEQ, 1 JUMP, 2 BR, 3 CALL, 4 RET, 5 LOOP, 6 ENDL, 7 HALT.
REQ-009 target  in  PC_W  absolute address for JUMP and CALL.
REQ-010 rel  in  REL_W  signed offset for BR.
REQ-011 loop_count  in  CNT_W  iteration count for LOOP.
REQ-012 cond  in  1  branch condition for BR, e.g. divergence consensus.
REQ-013 stall  in  1  freezes all sequencer state for the cycle.
REQ-014 resume  in  1  leaves HALTED state.
REQ-015 pc  out  PC_W  current program counter, registered.
REQ-016 next_pc  out  PC_W  combinational value pc takes at the next edge.
REQ-017 call_level  out  $clog2(CALL_DEPTH)+1  occupied call stack entries.
REQ-018 loop_level  out  $clog2(LOOP_DEPTH)+1  occupied loop stack entries.
REQ-019 halted  out  1  high while in HALTED state.
REQ-020 fault  out  1  high while in FAULT state.
REQ-021 fault_code  out  2  fault cause: 0 call overflow, 1 return underflow, 2 loop overflow, 3 loop underflow.

Function
REQ-022 The FSM SHALL have three states, RUN, HALTED and FAULT; pc SHALL load next_pc on every edge that is not a reset edge.
REQ-023 next_pc SHALL equal pc when the state is HALTED or FAULT, or when stall=1; all stacks, levels and state SHALL then hold, except for the transition in REQ-031.
REQ-024 In RUN with stall=0: SEQ gives pc+1; JUMP gives target; BR gives pc+sext(rel) if cond=1, else pc+1.
REQ-025 CALL SHALL push pc+1, increment call_level and give target.
REQ-026 RET SHALL give the top call entry and decrement call_level.
REQ-027 LOOP SHALL push {pc+1, count} and give pc+1, where count is loop_count, or 1 when loop_count is 0.
REQ-028 ENDL with top count >1 SHALL decrement the top count and give the top start address; with top count =1 it SHALL pop and give pc+1.
REQ-029 All pc arithmetic SHALL be modulo 2^PC_W; rel SHALL be sign-extended to PC_W.
REQ-030 HALT SHALL enter HALTED with pc held at the HALT address.
REQ-031 In HALTED, resume=1 with stall=0 SHALL return to RUN and give pc+1 on the same edge.
REQ-032 CALL at call_level=CALL_DEPTH, RET at call_level=0, LOOP at loop_level=LOOP_DEPTH, or ENDL at loop_level=0 SHALL enter FAULT with the matching fault_code.
REQ-033 On such a fault, pc, stacks and levels SHALL be left unchanged.
REQ-034 FAULT SHALL be sticky until rst; fault_code SHALL hold its value while fault=1.
REQ-035 CALL at call_level=CALL_DEPTH-1 SHALL succeed, giving call_level=CALL_DEPTH; LOOP at loop_level=LOOP_DEPTH-1 likewise.
REQ-036 The call stack and loop stack SHALL be independent; RET SHALL NOT alter loop state and ENDL SHALL NOT alter call state.
REQ-037 halted and fault SHALL be decoded directly from registered state.

Reset
REQ-038 On rst: pc=0, call_level=0, loop_level=0, state RUN, halted=0, fault=0, fault_code=0; stack contents need not be cleared.
REQ-039 rst SHALL take priority over stall, resume and any op, including mid-loop, mid-call and in FAULT.
REQ-040 On the cycle rst is high, next_pc SHALL be ignored.

Verification
REQ-041 Reset, then 3 SEQ -> pc 0,1,2,3; then BR rel=-2 cond=1 at pc=3 -> pc=1; then BR cond=0 at pc=1 -> pc=2.
REQ-042 CALL target=0x40 at pc=5, then RET at pc=0x41 -> pc 0x40, then 6; call_level 1 then 0.
REQ-043 LOOP loop_count=3 at pc=10, body pc=11, ENDL at pc=12 -> body executes 3 times, then pc=13, loop_level=0; loop_count=0 -> body executes once.
REQ-044 CALL_DEPTH CALLs succeed; the next CALL -> fault=1, fault_code=0, pc frozen; rst -> all outputs at reset values.
REQ-045 RET at reset -> fault_code=1; ENDL at reset -> fault_code=3; stall=1 during a CALL -> no push and pc held.
REQ-046 HALT at pc=7 -> halted=1, pc=7 for 5 cycles; resume=1 -> pc=8, halted=0; PC_W=4, JUMP 15 then SEQ -> pc=0.
